// File: rtl/shr_vram_if.sv
// Super Hires VRAM arbiter bus bundle.
// VGC read port, CPU shadow writes and block-RAM side.
interface shr_vram_if;
  logic        vgc_rd_i;
  logic [12:0] vgc_address_i;
  logic [31:0] vgc_data_o;
  logic        vgc_valid_o;
  logic        cpu_wr_i;
  logic [14:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_wr_ready_o;
  logic [12:0] ram_addr_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic        ram_rd_o;
  logic [31:0] ram_rdata_i;

  modport slave (
    input  vgc_rd_i,
    input  vgc_address_i,
    output vgc_data_o,
    output vgc_valid_o,
    input  cpu_wr_i,
    input  cpu_addr_i,
    input  cpu_data_i,
    output cpu_wr_ready_o,
    output ram_addr_o,
    output ram_we_o,
    output ram_be_o,
    output ram_wdata_o,
    output ram_rd_o,
    input  ram_rdata_i
  );

  modport master (
    output vgc_rd_i,
    output vgc_address_i,
    input  vgc_data_o,
    input  vgc_valid_o,
    output cpu_wr_i,
    output cpu_addr_i,
    output cpu_data_i,
    input  cpu_wr_ready_o,
    input  ram_addr_o,
    input  ram_we_o,
    input  ram_be_o,
    input  ram_wdata_o,
    input  ram_rd_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/shr_vram_arbiter.sv
// Super Hires VRAM arbiter: VGC reads win every slot,
// buffered CPU byte writes retire in the idle slots.
module shr_vram_arbiter #(
  parameter int FIFO_DEPTH  = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic       clk_pixel,
  input  logic       reset,
  shr_vram_if.slave  bus,
  output logic [5:0] fifo_level_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [12:0] word;
    logic [1:0]  lane;
    logic [7:0]  data;
  } wr_ent_t;

  wr_ent_t        fifo_mem [FIFO_DEPTH];
  wr_ent_t        head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           drop;
  logic [RAM_LATENCY:0] rd_sr;

  assign full  = fifo_level_o == 6'(FIFO_DEPTH);
  assign empty = fifo_level_o == 6'd0;
  assign push  = bus.cpu_wr_i && !full;
  assign drop  = bus.cpu_wr_i && full;
  assign pop   = !bus.vgc_rd_i && !empty;
  assign head  = fifo_mem[rd_ptr];

  assign bus.cpu_wr_ready_o = !full;
  assign bus.ram_rd_o       = rd_sr[0];

  // Write-entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{
        word: bus.cpu_addr_i[14:2],
        lane: bus.cpu_addr_i[1:0],
        data: bus.cpu_data_i
      };
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level_o <= fifo_level_o + 6'(push) - 6'(pop);
      if (drop) overflow_o <= 1'b1;
    end
  end

  // RAM slot: read strobe shift chain doubles as ram_rd_o.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rd_sr <= '0;
    end else begin
      rd_sr <= {rd_sr[RAM_LATENCY-1:0], bus.vgc_rd_i};
    end
  end

  // RAM address/write side; idle slots hold addr, be, wdata.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bus.ram_we_o    <= 1'b0;
      bus.ram_addr_o  <= '0;
      bus.ram_be_o    <= '0;
      bus.ram_wdata_o <= '0;
    end else begin
      bus.ram_we_o <= pop;
      if (bus.vgc_rd_i) begin
        bus.ram_addr_o <= bus.vgc_address_i;
      end else if (pop) begin
        bus.ram_addr_o  <= head.word;
        bus.ram_be_o    <= 4'b0001 << head.lane;
        bus.ram_wdata_o <= {4{head.data}};
      end
    end
  end

  // Read return: capture RAM data when its strobe matures.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bus.vgc_valid_o <= 1'b0;
      bus.vgc_data_o  <= '0;
    end else begin
      bus.vgc_valid_o <= rd_sr[RAM_LATENCY];
      if (rd_sr[RAM_LATENCY]) begin
        bus.vgc_data_o <= bus.ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_shr_vram_arbiter.sv
// Directed bench for shr_vram_arbiter with RAM model
// and read/write scoreboards.
module tb_shr_vram_arbiter;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [5:0] level;
  logic       ovf;

  shr_vram_if bus ();

  shr_vram_arbiter #(
    .FIFO_DEPTH (8),
    .RAM_LATENCY(1)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .bus         (bus),
    .fifo_level_o(level),
    .overflow_o  (ovf)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [12:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wexp_t;

  wexp_t       wq [$];
  logic [31:0] rq [$];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] ram [8192];
  logic        written [8192];
  logic        pre_en;
  logic [12:0] pre_a;
  logic [31:0] pre_d;
  logic [31:0] cur;

  function automatic logic [31:0] bg(input logic [12:0] a);
    return {16'hC0DE, 3'b000, a};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic exp_wr(input logic [14:0] a,
                        input logic [7:0] d);
    wexp_t e;
    e.a  = a[14:2];
    e.be = 4'b0001 << a[1:0];
    e.d  = {4{d}};
    wq.push_back(e);
  endtask

  // Block-RAM model, one cycle read latency.
  always @(posedge clk_pixel) begin
    if (pre_en) begin
      ram[pre_a]     <= pre_d;
      written[pre_a] <= 1'b1;
    end
    if (bus.ram_rd_o) begin
      bus.ram_rdata_i <= written[bus.ram_addr_o] ?
                         ram[bus.ram_addr_o] :
                         bg(bus.ram_addr_o);
    end
    if (bus.ram_we_o) begin
      cur = written[bus.ram_addr_o] ?
            ram[bus.ram_addr_o] : bg(bus.ram_addr_o);
      for (int n = 0; n < 4; n++) begin
        if (bus.ram_be_o[n]) cur[8*n+:8] = bus.ram_wdata_o[8*n+:8];
      end
      ram[bus.ram_addr_o]     <= cur;
      written[bus.ram_addr_o] <= 1'b1;
    end
  end

  // Scoreboard monitor on the falling edge.
  always @(negedge clk_pixel) begin
    wexp_t e;
    if (bus.ram_we_o && bus.ram_rd_o) begin
      chk("we_with_rd", 32'(bus.ram_we_o & bus.ram_rd_o), 32'd0);
    end
    if (bus.vgc_valid_o) begin
      if (rq.size() == 0) begin
        chk("rd_expected", 32'(rq.size()), 32'd1);
      end else begin
        chk("rd_data", bus.vgc_data_o, rq.pop_front());
      end
    end
    if (bus.ram_we_o) begin
      if (wq.size() == 0) begin
        chk("wr_expected", 32'(wq.size()), 32'd1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.ram_addr_o), 32'(e.a));
        chk("wr_be", 32'(bus.ram_be_o), 32'(e.be));
        chk("wr_data", bus.ram_wdata_o, e.d);
      end
    end
  end

  initial begin
    reset             = 1'b1;
    pre_en            = 1'b0;
    pre_a             = '0;
    pre_d             = '0;
    bus.vgc_rd_i      = 1'b0;
    bus.vgc_address_i = '0;
    bus.cpu_wr_i      = 1'b0;
    bus.cpu_addr_i    = '0;
    bus.cpu_data_i    = '0;
    for (int i = 0; i < 8192; i++) written[i] = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_vgc_data", bus.vgc_data_o, 32'd0);
    chk("rst_valid", 32'(bus.vgc_valid_o), 32'd0);
    chk("rst_we", 32'(bus.ram_we_o), 32'd0);
    chk("rst_rd", 32'(bus.ram_rd_o), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr_o), 32'd0);
    chk("rst_be", 32'(bus.ram_be_o), 32'd0);
    chk("rst_wdata", bus.ram_wdata_o, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ready", 32'(bus.cpu_wr_ready_o), 32'd1);
    repeat (10) tick();
    chk("idle_we", 32'(bus.ram_we_o), 32'd0);
    chk("idle_rd", 32'(bus.ram_rd_o), 32'd0);
    chk("idle_ready", 32'(bus.cpu_wr_ready_o), 32'd1);

    pre_en = 1'b1;
    pre_a  = 13'h1F40;
    pre_d  = 32'h12345678;
    tick();
    pre_en = 1'b0;

    // single CPU write
    bus.cpu_wr_i   = 1'b1;
    bus.cpu_addr_i = 15'h0005;
    bus.cpu_data_i = 8'hA7;
    exp_wr(15'h0005, 8'hA7);
    tick();
    bus.cpu_wr_i = 1'b0;
    chk("w1_level1", 32'(level), 32'd1);
    chk("w1_we_early", 32'(bus.ram_we_o), 32'd0);
    tick();
    chk("w1_we", 32'(bus.ram_we_o), 32'd1);
    chk("w1_addr", 32'(bus.ram_addr_o), 32'h0001);
    chk("w1_be", 32'(bus.ram_be_o), 32'h2);
    chk("w1_wdata", bus.ram_wdata_o, 32'hA7A7A7A7);
    chk("w1_level0", 32'(level), 32'd0);
    tick();

    // single VGC read
    bus.vgc_rd_i      = 1'b1;
    bus.vgc_address_i = 13'h1F40;
    rq.push_back(32'h12345678);
    tick();
    bus.vgc_rd_i = 1'b0;
    chk("r1_rd", 32'(bus.ram_rd_o), 32'd1);
    chk("r1_addr", 32'(bus.ram_addr_o), 32'h1F40);
    chk("r1_we", 32'(bus.ram_we_o), 32'd0);
    tick();
    chk("r1_valid_n2", 32'(bus.vgc_valid_o), 32'd0);
    tick();
    chk("r1_valid_n3", 32'(bus.vgc_valid_o), 32'd1);
    chk("r1_data_n3", bus.vgc_data_o, 32'h12345678);
    tick();
    chk("r1_valid_n4", 32'(bus.vgc_valid_o), 32'd0);
    chk("r1_hold", bus.vgc_data_o, 32'h12345678);

    // reads with simultaneous pushes: reads own the slots
    for (int i = 0; i < 4; i++) begin
      bus.vgc_rd_i      = 1'b1;
      bus.vgc_address_i = 13'h0100 + 13'(i);
      rq.push_back(bg(13'h0100 + 13'(i)));
      bus.cpu_wr_i   = 1'b1;
      bus.cpu_addr_i = 15'h0040 + 15'(3 * i);
      bus.cpu_data_i = 8'hB0 + 8'(i);
      exp_wr(15'h0040 + 15'(3 * i), 8'hB0 + 8'(i));
      tick();
      chk("mix_we_blocked", 32'(bus.ram_we_o), 32'd0);
      chk("mix_rd_slot", 32'(bus.ram_rd_o), 32'd1);
    end
    bus.vgc_rd_i = 1'b0;
    bus.cpu_wr_i = 1'b0;
    chk("mix_level4", 32'(level), 32'd4);
    tick();
    chk("mix_we_first", 32'(bus.ram_we_o), 32'd1);
    chk("mix_level3", 32'(level), 32'd3);
    repeat (4) tick();
    chk("mix_level0", 32'(level), 32'd0);
    chk("mix_we_done", 32'(bus.ram_we_o), 32'd0);

    // overflow while reads hold every slot
    for (int i = 0; i < 9; i++) begin
      chk("ovf_ready", 32'(bus.cpu_wr_ready_o), 32'(i < 8));
      chk("ovf_level", 32'(level), 32'(i));
      if (i == 7) chk("ovf_clear", 32'(ovf), 32'd0);
      bus.vgc_rd_i      = 1'b1;
      bus.vgc_address_i = 13'h0200;
      rq.push_back(bg(13'h0200));
      bus.cpu_wr_i   = 1'b1;
      bus.cpu_addr_i = 15'h2000 + 15'(5 * i);
      bus.cpu_data_i = 8'h60 + 8'(i);
      if (i < 8) exp_wr(15'h2000 + 15'(5 * i), 8'h60 + 8'(i));
      tick();
    end
    bus.vgc_rd_i = 1'b0;
    bus.cpu_wr_i = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_full", 32'(level), 32'd8);
    chk("ovf_not_ready", 32'(bus.cpu_wr_ready_o), 32'd0);
    repeat (12) tick();
    chk("ovf_drain", 32'(level), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_ready_again", 32'(bus.cpu_wr_ready_o), 32'd1);

    // reset with reads in flight and writes queued
    for (int i = 0; i < 3; i++) begin
      bus.vgc_rd_i      = 1'b1;
      bus.vgc_address_i = 13'h0300 + 13'(i);
      rq.push_back(bg(13'h0300 + 13'(i)));
      bus.cpu_wr_i   = 1'b1;
      bus.cpu_addr_i = 15'h3000 + 15'(i);
      bus.cpu_data_i = 8'hE0 + 8'(i);
      exp_wr(15'h3000 + 15'(i), 8'hE0 + 8'(i));
      tick();
    end
    bus.cpu_wr_i      = 1'b0;
    bus.vgc_address_i = 13'h0303;
    rq.push_back(bg(13'h0303));
    tick();
    bus.vgc_rd_i = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    rq.delete();
    wq.delete();
    chk("rr_valid", 32'(bus.vgc_valid_o), 32'd0);
    chk("rr_data", bus.vgc_data_o, 32'd0);
    chk("rr_level", 32'(level), 32'd0);
    chk("rr_ovf", 32'(ovf), 32'd0);
    chk("rr_we", 32'(bus.ram_we_o), 32'd0);
    chk("rr_rd", 32'(bus.ram_rd_o), 32'd0);
    chk("rr_ready", 32'(bus.cpu_wr_ready_o), 32'd1);
    repeat (8) tick();
    chk("rr_level_idle", 32'(level), 32'd0);
    chk("rr_mem_untouched",
        written[13'h0C00] ? 32'd1 : 32'd0, 32'd0);

    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shr_vram_arbiter.md
Name: shr_vram_arbiter

Overview:
- Arbitrates the 32-bit Super Hires video RAM (8192 words, shadow of bank $E1 $2000-$9FFF) between the VGC read port and CPU shadow byte writes.
- VGC reads have absolute priority and a fixed read latency.
- CPU writes are buffered in a small FIFO and retired in cycles with no VGC read.
- Sits between the VGC memory interface and the block-RAM instance, all in the clk_pixel domain.

Parameters:
- FIFO_DEPTH, 8, number of CPU write entries buffered (power of two, 2..32).
- RAM_LATENCY, 1, clocks from RAM address/strobe to valid ram_rdata_i (1..4).

Ports:
- clk_pixel  in  1  pixel clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- vgc_rd_i  in  1  VGC read strobe, one-cycle pulse.
- vgc_address_i  in  13  VGC word address.
- vgc_data_o  out  32  read data returned to the VGC; held until the next return.
- vgc_valid_o  out  1  one-cycle pulse when vgc_data_o updates.
- cpu_wr_i  in  1  CPU shadow write strobe.
- cpu_addr_i  in  15  byte offset within the shadow region ($0000-$7FFF).
- cpu_data_i  in  8  write byte.
- cpu_wr_ready_o  out  1  high when the FIFO is not full.
- ram_addr_o  out  13  RAM word address.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables; bit n covers bits [8n+7:8n].
- ram_wdata_o  out  32  RAM write data.
- ram_rd_o  out  1  RAM read strobe.
- ram_rdata_i  in  32  RAM read data.
- fifo_level_o  out  6  current FIFO occupancy.
- overflow_o  out  1  sticky flag: a CPU write was dropped.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO is emptied.
  - The read pipeline is flushed; no vgc_valid_o fires for a read in flight.
  - vgc_data_o=0, vgc_valid_o=0, ram_we_o=0, ram_rd_o=0, ram_addr_o=0, ram_be_o=0, ram_wdata_o=0, fifo_level_o=0, overflow_o=0.
  - cpu_wr_ready_o=1 in the first cycle after reset.
- CPU push:
  - In cycle N, cpu_wr_i with cpu_wr_ready_o=1 pushes {cpu_addr_i[14:2], cpu_addr_i[1:0], cpu_data_i}.
  - cpu_wr_ready_o reflects occupancy at the start of cycle N. A pop in the same cycle does not permit a push into a full FIFO (no bypass).
  - Push while full: the write is dropped and overflow_o is set. overflow_o clears only on reset.
- Arbitration, evaluated each cycle N:
  - If vgc_rd_i: read slot. At N+1, ram_rd_o=1, ram_we_o=0, ram_addr_o=vgc_address_i. The FIFO does not pop.
  - Else if the FIFO is non-empty: pop the head. At N+1, ram_we_o=1, ram_addr_o=word address, ram_be_o=one-hot(byte lane), ram_wdata_o=byte replicated into all four lanes.
  - Else: idle. At N+1, ram_rd_o=0 and ram_we_o=0; addr, be and wdata hold their previous values.
- Read return:
  - ram_rdata_i is sampled at N+1+RAM_LATENCY.
  - vgc_data_o updates and vgc_valid_o pulses in cycle N+2+RAM_LATENCY (N+3 at the default).
  - Back-to-back reads every cycle are supported; returns stay in order, one per cycle.
  - Worst-case latency must stay within the VGC's 13-cycle window; RAM_LATENCY ≤ 4 guarantees this.
- Ordering and hazards:
  - Writes retire in FIFO order.
  - No read-after-write forwarding: a VGC read of a word with a pending FIFO write returns old RAM contents, matching real-hardware tearing.
- Simultaneous events:
  - Push and pop in the same cycle leave fifo_level_o unchanged.
  - vgc_rd_i and cpu_wr_i together: the read wins the RAM slot and the push still occurs.
- fifo_level_o counts 0..FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Writes are never starved: the VGC reads at most 1 cycle in 16 in normal operation. No timeout logic is required.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, cpu_wr_ready_o=1, no RAM strobes.
- cpu_wr_i addr=15'h0005 data=8'hA7, no reads -> ram_we_o=1 at N+1, ram_addr_o=13'h0001, ram_be_o=4'b0010, ram_wdata_o=32'hA7A7A7A7; fifo_level_o returns to 0.
- vgc_rd_i addr=13'h1F40 with RAM preloaded 32'h12345678 there -> ram_rd_o at N+1; vgc_data_o=32'h12345678 with vgc_valid_o pulse at N+3; data holds afterwards.
- 3 consecutive vgc_rd_i pulses while 4 writes are queued -> no ram_we_o during the 3 read slots; reads return in order at N+3..N+5; writes retire in cycles N+4..N+7.
- 9 CPU writes in consecutive cycles while vgc_rd_i is held high (FIFO_DEPTH=8) -> cpu_wr_ready_o drops after the 8th, 9th is dropped, overflow_o=1, fifo_level_o=8; release reads -> 8 writes retire in order, overflow_o stays 1.
- Assert reset one cycle after vgc_rd_i with 3 writes queued -> no vgc_valid_o, fifo_level_o=0, queued writes never reach RAM.
